// File: rtl/fifo_drain_control.sv
// Read-side drain controller for the per-lane input FIFOs: skewed (systolic) read enables + aligned valids.
// Optional build macro STALL_COUNTER_EN adds a saturating stall_cycles output.

module fifo_drain_lane #(
    parameter int LANE = 0,
    parameter int TW   = 17,
    parameter int LW   = 16
) (
    input  logic [TW-1:0] t_i,
    input  logic [LW-1:0] len_i,
    output logic          need_o
);
    localparam logic [TW-1:0] K = TW'(LANE);

    logic [TW-1:0] end_w;

    // Lane k is active for steps k .. k+len-1; TW is one bit wider than len so this cannot wrap.
    assign end_w  = K + TW'(len_i);
    assign need_o = (t_i >= K) && (t_i < end_w);
endmodule

module fifo_drain_control #(
    parameter int array_size    = 9,
    parameter int dim_data_size = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     enable,
    input  logic [array_size-1:0]    fifo_empty,
    input  logic [dim_data_size-1:0] weight_size,
    input  logic [dim_data_size-1:0] image_height,
    input  logic [dim_data_size-1:0] image_width,
    output logic [array_size-1:0]    read_enable_out,
    output logic [array_size-1:0]    valid_out,
    output logic                     busy,
    output logic                     completed,
`ifdef STALL_COUNTER_EN
    output logic [15:0]              stall_cycles,
`endif
    output logic [2:0]               state
);
    localparam int LW = 2 * dim_data_size;
    localparam int TW = 2 * dim_data_size + 1;

    typedef enum logic [2:0] {
        IDLE = 3'b000,
        CALC = 3'b001,
        RUN  = 3'b010,
        DONE = 3'b011
    } state_t;

    state_t                state_q, state_d;
    logic [TW-1:0]         t_q, t_d;
    logic [LW-1:0]         len_q, len_d;
    logic [array_size-1:0] valid_q;
    logic [array_size-1:0] need;
    logic [LW-1:0]         rows_w, cols_w, calc_len;
    logic [TW-1:0]         last_step;
    logic                  dims_ok, go;
    logic                  stall_inc, stall_clr;

    for (genvar k = 0; k < array_size; k++) begin : g_lane
        fifo_drain_lane #(.LANE(k), .TW(TW), .LW(LW)) u_lane (
            .t_i    (t_q),
            .len_i  (len_q),
            .need_o (need[k])
        );
    end

    assign dims_ok   = (weight_size != '0) && (weight_size <= image_height)
                       && (weight_size <= image_width);
    assign rows_w    = LW'(image_height) - LW'(weight_size) + LW'(1);
    assign cols_w    = LW'(image_width) - LW'(weight_size) + LW'(1);
    assign calc_len  = rows_w * cols_w;
    assign last_step = TW'(len_q) + TW'(array_size - 2);
    // A single empty needed lane holds every lane, keeping the diagonal skew intact.
    assign go        = enable && (state_q == RUN) && ((need & fifo_empty) == '0);

    always_comb begin
        state_d         = state_q;
        t_d             = t_q;
        len_d           = len_q;
        read_enable_out = '0;
        stall_inc       = 1'b0;
        stall_clr       = 1'b0;
        if (enable) begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d   = CALC;
                        stall_clr = 1'b1;
                    end
                end
                CALC: begin
                    if (dims_ok) begin
                        len_d   = calc_len;
                        t_d     = '0;
                        state_d = RUN;
                    end else begin
                        len_d   = '0;
                        state_d = DONE;
                    end
                end
                RUN: begin
                    if (go) begin
                        read_enable_out = need;
                        t_d             = t_q + TW'(1);
                        if (t_q == last_step) state_d = DONE;
                    end else begin
                        stall_inc = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            t_q     <= '0;
            len_q   <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            len_q   <= len_d;
            // FIFO data appears one cycle after the read; enable=0 already forces the read to 0.
            valid_q <= read_enable_out;
        end
    end

`ifdef STALL_COUNTER_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                               stall_q <= '0;
        else if (stall_clr)                      stall_q <= '0;
        else if (stall_inc && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
    end

    assign stall_cycles = stall_q;
`endif

    assign valid_out = valid_q;
    assign busy      = (state_q == CALC) || (state_q == RUN);
    assign completed = (state_q == DONE);
    assign state     = state_q;
endmodule

// File: doc/fifo_drain_control.md
Name: fifo_drain_control

Overview:
- Read-side controller for the per-lane input FIFOs that the fill controller loads from InputDataROM.
- Issues per-lane FIFO read enables with systolic diagonal skew: lane k starts k steps after lane 0.
- Produces per-lane valid strobes aligned to FIFO read data, for the processing-element array.
- Lanes advance in lockstep, so skew is preserved across stalls.

Parameters:
- array_size, 9: number of FIFO lanes / array rows.
- dim_data_size, 8: width of the dimension inputs.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin draining; sampled only in IDLE or DONE.
- enable  input  1  low freezes all state; no reads issued.
- fifo_empty  input  array_size  per-lane FIFO empty flags.
- weight_size  input  dim_data_size  kernel edge length.
- image_height  input  dim_data_size  image rows.
- image_width  input  dim_data_size  image columns.
- read_enable_out  output  array_size  per-lane FIFO read strobes.
- valid_out  output  array_size  per-lane data-valid strobes, one cycle after the read.
- busy  output  1  high in CALC and RUN.
- completed  output  1  high in DONE.
- state  output  3  current FSM state.

Behaviour:
- Reset: state=IDLE, t=0, stream_len=0; read_enable_out=0, valid_out=0, busy=0, completed=0.
- Reset asserted mid-operation aborts immediately; no further reads.
- FSM encodings: IDLE=3'b000, CALC=3'b001, RUN=3'b010, DONE=3'b011.
- IDLE: start=1 and enable=1 -> CALC.
- CALC (1 cycle): latch stream_len = (image_height-weight_size+1)*(image_width-weight_size+1), computed unsigned at 2*dim_data_size bits.
  - If weight_size=0, weight_size>image_height, or weight_size>image_width: stream_len=0 -> DONE, no reads.
  - Otherwise t<=0 -> RUN.
- RUN, per step t:
  - need[k] = (t>=k) && (t<k+stream_len).
  - go = enable && ((need & fifo_empty)==0).
  - read_enable_out = need when go, else 0. This is combinational from registered t/stream_len and inputs.
  - On go, t<=t+1.
  - If go and t==stream_len+array_size-2 -> DONE.
- Stall: any needed lane empty -> no lane reads that cycle; t holds.
- valid_out: register of read_enable_out (FIFO read latency 1). Reset to 0. Also cleared whenever enable=0 during RUN.
- DONE: completed=1, held.
  - start=1 with enable=1 clears completed and -> CALC (restart).
  - Dimension inputs are re-sampled only in CALC. Changes during RUN are ignored.
- start during CALC/RUN is ignored.
- enable=0 in any state freezes state and counters; read_enable_out=0.
- t width: 2*dim_data_size+1 bits; no wrap within a legal run.

Optional Feature:
- Macro STALL_COUNTER_EN.
- Defined:
  - Adds output stall_cycles (16 bits).
  - Counts RUN cycles with enable=1 and go=0; saturates at 16'hFFFF.
  - Cleared by reset and on CALC entry; held in DONE.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- weight_size=3, image 5x5, all FIFOs non-empty, start at cycle 0:
  - CALC at cycle 1; RUN cycles 2-18.
  - read_enable_out[0] high cycles 2-10; read_enable_out[8] high cycles 10-18.
  - valid_out mirrors each lane one cycle later; completed=1 from cycle 19; 81 reads total.
- Same setup, fifo_empty[4]=1 for 3 cycles while t=6:
  - read_enable_out=0 on all lanes for those 3 cycles; RUN lasts 20 cycles.
  - stall_cycles=3 (with STALL_COUNTER_EN).
- weight_size=6, image 5x5:
  - CALC -> DONE; read_enable_out never asserted; completed=1 two cycles after start.
- Reset during RUN at t=5:
  - All outputs 0 in the same cycle; state=IDLE.
  - A subsequent start reruns the full 17-step sequence.
- enable low for 4 cycles at t=10:
  - t frozen; read_enable_out and valid_out 0; resumes at t=10.
  - Lane reads total unchanged (81).
- In DONE, pulse start with weight_size=1, image 2x2:
  - completed clears; stream_len=4.
  - lane k reads at steps k..k+3; 12 steps total.
